// File: rtl/linked_list_fifo_shared_pkg.sv
// Shared parameters and helpers for the shared-pool linked-list FIFO.
package linked_list_fifo_shared_pkg;

  localparam int unsigned LLF_WIDTH = 8;
  localparam int unsigned LLF_DEPTH = 32;
  localparam int unsigned LLF_FIFOS = 8;

  // Number of bits needed to represent n (at least 1).
  function automatic int unsigned bits_for(input int unsigned n);
    int unsigned b;
    b = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((n >> i) != 0) b = i + 1;
    end
    return b;
  endfunction

endpackage

// File: rtl/linked_list_fifo_shared_ram.sv
// Node pool storage: DEPTH words of {next, data}.
// Ports:
//   rd_en/rd_addr/rd_data        synchronous data read, read-old-data on collision
//   nxt_addr_a/b, nxt_a/b        combinational next-pointer reads (head and free-head advance)
//   data_we/data_addr/data_wdata data field write
//   next_we/next_addr/next_wdata next-pointer field write
module linked_list_fifo_shared_ram #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 32,
  parameter int unsigned PTR_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rd_en,
  input  logic [PTR_W-1:0] rd_addr,
  output logic [WIDTH-1:0] rd_data,
  input  logic [PTR_W-1:0] nxt_addr_a,
  output logic [PTR_W-1:0] nxt_a,
  input  logic [PTR_W-1:0] nxt_addr_b,
  output logic [PTR_W-1:0] nxt_b,
  input  logic             data_we,
  input  logic [PTR_W-1:0] data_addr,
  input  logic [WIDTH-1:0] data_wdata,
  input  logic             next_we,
  input  logic [PTR_W-1:0] next_addr,
  input  logic [PTR_W-1:0] next_wdata
);

  localparam int unsigned WORD_W = WIDTH + PTR_W;

  logic [WORD_W-1:0] mem [DEPTH];

  // Storage is never reset; only the read register is.
  always_ff @(posedge clk) begin
    if (data_we) mem[data_addr][WIDTH-1:0]      <= data_wdata;
    if (next_we) mem[next_addr][WORD_W-1:WIDTH] <= next_wdata;
  end

  // Sync read samples the pre-edge word, so a same-edge write is not seen.
  always_ff @(posedge clk) begin
    if (!rst_n)     rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr][WIDTH-1:0];
  end

  assign nxt_a = mem[nxt_addr_a][WORD_W-1:WIDTH];
  assign nxt_b = mem[nxt_addr_b][WORD_W-1:WIDTH];

endmodule

// File: rtl/linked_list_fifo_shared.sv
// FIFOS logical queues sharing one DEPTH-entry node pool via per-node next pointers.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   push/push_fifo/d      enqueue request, target queue, data
//   pop/pop_fifo          dequeue request, source queue
//   q/q_valid             popped data (1-cycle latency), valid pulse for accepted pop
//   empty                 per-queue empty flags (from registered counts)
//   full/pool_used        pool fully occupied / total occupied nodes
//   count                 per-queue occupancy, CNT_W bits per queue
//   overflow/underflow    sticky rejected-push / rejected-pop flags
module linked_list_fifo_shared
  import linked_list_fifo_shared_pkg::*;
#(
  parameter  int unsigned WIDTH      = LLF_WIDTH,
  parameter  int unsigned DEPTH      = LLF_DEPTH,
  parameter  int unsigned FIFOS      = LLF_FIFOS,
  localparam int unsigned FIFO_LOG2  = bits_for(FIFOS - 1),
  localparam int unsigned DEPTH_LOG2 = bits_for(DEPTH - 1),
  localparam int unsigned CNT_W      = DEPTH_LOG2 + 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [FIFO_LOG2-1:0]   push_fifo,
  input  logic [WIDTH-1:0]       d,
  input  logic                   pop,
  input  logic [FIFO_LOG2-1:0]   pop_fifo,
  output logic [WIDTH-1:0]       q,
  output logic                   q_valid,
  output logic [FIFOS-1:0]       empty,
  output logic                   full,
  output logic [CNT_W*FIFOS-1:0] count,
  output logic [CNT_W-1:0]       pool_used,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int unsigned PTR_W = DEPTH_LOG2;

  logic [PTR_W-1:0] head_r  [FIFOS];
  logic [PTR_W-1:0] tail_r  [FIFOS];
  logic [CNT_W-1:0] count_r [FIFOS];
  logic [CNT_W-1:0] pool_used_r;
  logic [CNT_W-1:0] fresh_r;
  logic [PTR_W-1:0] free_head_r;
  logic             q_valid_r;
  logic             overflow_r;
  logic             underflow_r;

  logic             push_ok;
  logic             pop_ok;
  logic             same_q;
  logic             fresh_avail;
  logic             push_to_empty;
  logic [PTR_W-1:0] pop_head;
  logic [PTR_W-1:0] pop_next;
  logic [PTR_W-1:0] free_next;
  logic [PTR_W-1:0] node;
  logic             next_we;
  logic [PTR_W-1:0] next_addr;
  logic [PTR_W-1:0] next_wdata;

  // Output views of the per-queue registers.
  always_comb begin
    empty = '0;
    count = '0;
    for (int unsigned i = 0; i < FIFOS; i++) begin
      empty[i]               = (count_r[i] == '0);
      count[i*CNT_W +: CNT_W] = count_r[i];
    end
  end

  assign full      = (pool_used_r == CNT_W'(DEPTH));
  assign pool_used = pool_used_r;
  assign q_valid   = q_valid_r;
  assign overflow  = overflow_r;
  assign underflow = underflow_r;

  // Acceptance, node selection and link-write decode from pre-edge state.
  always_comb begin
    push_ok     = push & ~full;
    pop_ok      = pop & ~empty[pop_fifo];
    same_q      = (push_fifo == pop_fifo);
    fresh_avail = (fresh_r < CNT_W'(DEPTH));
    pop_head    = head_r[pop_fifo];
    // A same-queue pop that drains the last node makes the push land in an empty queue.
    push_to_empty = (count_r[push_fifo] == '0) ||
                    (pop_ok && same_q && (count_r[push_fifo] == CNT_W'(1)));
    if (pop_ok)           node = pop_head;
    else if (fresh_avail) node = fresh_r[PTR_W-1:0];
    else                  node = free_head_r;

    next_we    = 1'b0;
    next_addr  = '0;
    next_wdata = '0;
    if (push_ok && !push_to_empty) begin
      next_we    = 1'b1;
      next_addr  = tail_r[push_fifo];
      next_wdata = node;
    end else if (pop_ok && !push_ok) begin
      next_we    = 1'b1;
      next_addr  = pop_head;
      next_wdata = free_head_r;
    end
  end

  linked_list_fifo_shared_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_ram (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_en      (pop_ok),
    .rd_addr    (pop_head),
    .rd_data    (q),
    .nxt_addr_a (pop_head),
    .nxt_a      (pop_next),
    .nxt_addr_b (free_head_r),
    .nxt_b      (free_next),
    .data_we    (push_ok),
    .data_addr  (node),
    .data_wdata (d),
    .next_we    (next_we),
    .next_addr  (next_addr),
    .next_wdata (next_wdata)
  );

  // Queue pointers, counters, allocator and status flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < FIFOS; i++) begin
        head_r[i]  <= '0;
        tail_r[i]  <= '0;
        count_r[i] <= '0;
      end
      pool_used_r <= '0;
      fresh_r     <= '0;
      free_head_r <= '0;
      q_valid_r   <= 1'b0;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      q_valid_r <= pop_ok;
      if (push && !push_ok) overflow_r  <= 1'b1;
      if (pop && !pop_ok)   underflow_r <= 1'b1;

      if (pop_ok) begin
        head_r[pop_fifo] <= pop_next;
        if (!(push_ok && same_q)) count_r[pop_fifo] <= count_r[pop_fifo] - CNT_W'(1);
      end

      // Placed after the pop update so a refill of a drained queue wins the head.
      if (push_ok) begin
        if (push_to_empty) head_r[push_fifo] <= node;
        tail_r[push_fifo] <= node;
        if (!(pop_ok && same_q)) count_r[push_fifo] <= count_r[push_fifo] + CNT_W'(1);
      end

      // Freed node is handed straight to a simultaneous push, bypassing the free list.
      if (push_ok && !pop_ok) begin
        pool_used_r <= pool_used_r + CNT_W'(1);
        if (fresh_avail) fresh_r     <= fresh_r + CNT_W'(1);
        else             free_head_r <= free_next;
      end else if (pop_ok && !push_ok) begin
        pool_used_r <= pool_used_r - CNT_W'(1);
        free_head_r <= pop_head;
      end
    end
  end

endmodule

// File: tb/tb_linked_list_fifo_shared.sv
// Bench for linked_list_fifo_shared: directed scenarios plus random traffic against a queue model.
module tb_linked_list_fifo_shared;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 32;
  localparam int unsigned FIFOS = 8;
  localparam int unsigned FL    = 3;
  localparam int unsigned CW    = 6;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                push;
  logic [FL-1:0]       push_fifo;
  logic [WIDTH-1:0]    d;
  logic                pop;
  logic [FL-1:0]       pop_fifo;
  logic [WIDTH-1:0]    q;
  logic                q_valid;
  logic [FIFOS-1:0]    empty;
  logic                full;
  logic [CW*FIFOS-1:0] count;
  logic [CW-1:0]       pool_used;
  logic                overflow;
  logic                underflow;

  always #5 clk = ~clk;

  linked_list_fifo_shared dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_fifo (push_fifo),
    .d         (d),
    .pop       (pop),
    .pop_fifo  (pop_fifo),
    .q         (q),
    .q_valid   (q_valid),
    .empty     (empty),
    .full      (full),
    .count     (count),
    .pool_used (pool_used),
    .overflow  (overflow),
    .underflow (underflow)
  );

  // Reference model: one plain queue per logical FIFO.
  logic [WIDTH-1:0] mq [FIFOS][$];
  logic [WIDTH-1:0] exp_q;
  bit               exp_qv;
  bit               exp_ovf;
  bit               exp_unf;
  int               total;
  int               bad;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int model_used();
    int s;
    s = 0;
    for (int i = 0; i < FIFOS; i++) s += mq[i].size();
    return s;
  endfunction

  task automatic compare_all();
    int used;
    used = model_used();
    check("q_valid", 64'(q_valid), 64'(exp_qv));
    check("q", 64'(q), 64'(exp_q));
    for (int i = 0; i < FIFOS; i++) begin
      check($sformatf("count%0d", i), 64'(count[i*CW +: CW]), 64'(mq[i].size()));
      check($sformatf("empty%0d", i), 64'(empty[i]), 64'(mq[i].size() == 0));
    end
    check("pool_used", 64'(pool_used), 64'(used));
    check("full", 64'(full), 64'(used == DEPTH));
    check("overflow", 64'(overflow), 64'(exp_ovf));
    check("underflow", 64'(underflow), 64'(exp_unf));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    push  = 1'b0;
    pop   = 1'b0;
    @(posedge clk);
    for (int i = 0; i < FIFOS; i++) mq[i].delete();
    exp_q   = '0;
    exp_qv  = 1'b0;
    exp_ovf = 1'b0;
    exp_unf = 1'b0;
    #1;
    rst_n = 1'b1;
    compare_all();
  endtask

  // One clock of stimulus; the model applies the same request using pre-edge occupancy.
  task automatic step(input bit ps, input int pf, input logic [WIDTH-1:0] dd,
                      input bit pp, input int of);
    bit pok;
    bit popok;
    push      = ps;
    push_fifo = FL'(pf);
    d         = dd;
    pop       = pp;
    pop_fifo  = FL'(of);
    @(posedge clk);
    pok   = ps && (model_used() < DEPTH);
    popok = pp && (mq[of].size() != 0);
    if (ps && !pok)  exp_ovf = 1'b1;
    if (pp && !popok) exp_unf = 1'b1;
    exp_qv = popok;
    if (popok) exp_q = mq[of].pop_front();
    if (pok)   mq[pf].push_back(dd);
    #1;
    push = 1'b0;
    pop  = 1'b0;
    compare_all();
  endtask

  initial begin
    int pct;
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    push = 1'b0; pop = 1'b0; push_fifo = '0; pop_fifo = '0; d = '0;

    // Basic order on one queue.
    do_reset();
    step(1, 3, 8'hA1, 0, 0);
    step(1, 3, 8'hA2, 0, 0);
    step(0, 0, 8'h00, 1, 3);
    check("t1_q_first", 64'(q), 64'hA1);
    step(0, 0, 8'h00, 1, 3);
    check("t1_q_second", 64'(q), 64'hA2);
    check("t1_empty3", 64'(empty[3]), 64'd1);

    // Whole pool into one queue, then overflow.
    do_reset();
    for (int i = 0; i < DEPTH; i++) step(1, 0, 8'(i + 8'h10), 0, 0);
    check("t2_full", 64'(full), 64'd1);
    step(1, 0, 8'hEE, 0, 0);
    check("t2_overflow", 64'(overflow), 64'd1);
    check("t2_count0", 64'(count[0 +: CW]), 64'd32);

    // Free-list reuse into another queue, then drain it in order.
    for (int i = 0; i < 5; i++) step(0, 0, 8'h00, 1, 0);
    for (int i = 0; i < 5; i++) step(1, 7, 8'(8'hC0 + i), 0, 0);
    check("t3_pool_used", 64'(pool_used), 64'd32);
    for (int i = 0; i < 5; i++) step(0, 0, 8'h00, 1, 7);
    check("t3_q_last", 64'(q), 64'hC4);

    // Same-queue push+pop with a single entry.
    do_reset();
    step(1, 2, 8'h55, 0, 0);
    step(1, 2, 8'h66, 1, 2);
    check("t4_q_old", 64'(q), 64'h55);
    check("t4_count2", 64'(count[2*CW +: CW]), 64'd1);
    step(0, 0, 8'h00, 1, 2);
    check("t4_q_new", 64'(q), 64'h66);

    // Pop of an empty queue.
    step(1, 1, 8'h77, 0, 0);
    step(0, 0, 8'h00, 1, 4);
    check("t5_underflow", 64'(underflow), 64'd1);
    check("t5_q_valid", 64'(q_valid), 64'd0);

    // Random traffic with a mid-run reset.
    do_reset();
    pct = 50;
    for (int c = 0; c < 10000; c++) begin
      if (c % 500 == 0) begin
        case ($urandom_range(0, 2))
          0:       pct = 30;
          1:       pct = 50;
          default: pct = 85;
        endcase
      end
      if (c == 5000) begin
        do_reset();
        check("rand_reset_empty", 64'(empty), 64'hFF);
      end
      step($urandom_range(0, 99) < pct, int'($urandom_range(0, FIFOS - 1)),
           WIDTH'($urandom), $urandom_range(0, 99) < (100 - pct),
           int'($urandom_range(0, FIFOS - 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
